// File: rtl/struct_record_serializer.sv
// Buffers 41-bit {flag, value, tag} records in a small FIFO and emits each one as a
// header word followed by a value word. Define STRUCT_SER_CHECKSUM_EN to append a checksum word.
module struct_record_serializer #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter logic [7:0]  HDR_MARK   = 8'h5A
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [40:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        busy,
   output logic [15:0] records_sent
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [AW:0] FullCnt = (AW+1)'(FIFO_DEPTH);

`ifdef STRUCT_SER_CHECKSUM_EN
   typedef enum logic [1:0] {StIdle, StHdr, StVal, StCsum} state_e;
`else
   typedef enum logic [1:0] {StIdle, StHdr, StVal} state_e;
`endif

   state_e         state_q, state_d;
   logic [40:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AW:0]    count_q;
   logic [40:0]    rec_q;
   logic [15:0]    records_sent_q;
   logic           fifo_empty, fifo_full, push, pop, accept, last_state, rec_done;
   logic [31:0]    hdr_word;

   assign fifo_empty   = (count_q == '0);
   assign fifo_full    = (count_q == FullCnt);
   // Ready depends only on registered occupancy, never on a same-cycle pop.
   assign in_ready     = reset && !fifo_full;
   assign push         = in_valid && in_ready;
   assign accept       = out_valid && out_ready;
   assign rec_done     = accept && last_state;
   assign hdr_word     = {HDR_MARK, 7'b0, rec_q[40], 8'h00, rec_q[7:0]};
   assign records_sent = records_sent_q;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         rec_q          <= '0;
         records_sent_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
            rec_q    <= mem_q[rd_ptr_q];
         end
         if (push && !pop)      count_q <= count_q + (AW+1)'(1);
         else if (!push && pop) count_q <= count_q - (AW+1)'(1);
         if (rec_done) records_sent_q <= records_sent_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = StHdr;
            end
         end
         StHdr: if (out_ready) state_d = StVal;
`ifdef STRUCT_SER_CHECKSUM_EN
         StVal: if (out_ready) state_d = StCsum;
         StCsum: ;
`else
         StVal: ;
`endif
         default: state_d = StIdle;
      endcase
      // Chain straight into the next header when a record is already queued.
      if (rec_done) begin
         if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = StHdr;
         end else begin
            state_d = StIdle;
         end
      end
   end

   always_comb begin
      out_valid  = 1'b0;
      out_data   = '0;
      last_state = 1'b0;
      unique case (state_q)
         StIdle: ;
         StHdr: begin
            out_valid = 1'b1;
            out_data  = hdr_word;
         end
         StVal: begin
            out_valid = 1'b1;
            out_data  = rec_q[39:8];
`ifndef STRUCT_SER_CHECKSUM_EN
            last_state = 1'b1;
`endif
         end
`ifdef STRUCT_SER_CHECKSUM_EN
         StCsum: begin
            out_valid  = 1'b1;
            out_data   = hdr_word ^ rec_q[39:8];
            last_state = 1'b1;
         end
`endif
         default: ;
      endcase
      out_last = last_state;
      busy     = !fifo_empty || (state_q != StIdle);
   end

endmodule

// File: tb/tb_struct_record_serializer.sv
// Directed bench for struct_record_serializer with a word-queue reference model
// checked on every falling edge.
module tb_struct_record_serializer;

`ifdef STRUCT_SER_CHECKSUM_EN
   localparam int WPR = 3;
`else
   localparam int WPR = 2;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [40:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic [15:0] records_sent;

   int checks = 0;
   int errors = 0;

   struct_record_serializer #(.FIFO_DEPTH(2), .HDR_MARK(8'h5A)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last),
      .busy         (busy),
      .records_sent (records_sent)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: every accepted push appends its words to an expected stream.
   logic [31:0] exp_data[$];
   logic        exp_last[$];
   logic [15:0] rs_model = '0;
   logic        hold_pend = 1'b0;
   logic [31:0] hold_data;
   logic        hold_last;

   function automatic logic [31:0] hdr_of(input logic [40:0] r);
      return {8'h5A, 7'b0, r[40], 8'h00, r[7:0]};
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         exp_data.delete();
         exp_last.delete();
         rs_model  = '0;
         hold_pend = 1'b0;
      end else begin
         chk("model_busy", 32'(busy), 32'(exp_data.size() != 0));
         chk("model_records_sent", 32'(records_sent), 32'(rs_model));
         if (hold_pend) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, hold_data);
            chk("hold_last", 32'(out_last), 32'(hold_last));
         end
         hold_pend = 1'b0;
         if (out_valid) begin
            if (exp_data.size() == 0) begin
               chk("stale_word", 32'(out_valid), 32'd0);
            end else begin
               chk("model_data", out_data, exp_data[0]);
               chk("model_last", 32'(out_last), 32'(exp_last[0]));
               if (out_ready) begin
                  if (exp_last[0]) rs_model = rs_model + 16'd1;
                  void'(exp_data.pop_front());
                  void'(exp_last.pop_front());
               end else begin
                  hold_pend = 1'b1;
                  hold_data = out_data;
                  hold_last = out_last;
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_data.push_back(hdr_of(in_data));
            exp_last.push_back(1'b0);
            exp_data.push_back(in_data[39:8]);
            exp_last.push_back(WPR == 2);
            if (WPR == 3) begin
               exp_data.push_back(hdr_of(in_data) ^ in_data[39:8]);
               exp_last.push_back(1'b1);
            end
         end
      end
   end

   task automatic drain();
      int n = 0;
      while (busy && n < 200) begin
         step();
         n++;
      end
      chk("drain_idle", 32'(busy), 32'd0);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 50) begin
         step();
         n++;
      end
      chk("wait_valid", 32'(out_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rs0;

      // Reset state
      step();
      step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_records_sent", 32'(records_sent), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      reset = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      step();

      // Single record, latency and literal words
      out_ready = 1'b1;
      in_data   = {1'b0, 32'd100, 8'd10};
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t1_lat_idle", 32'(out_valid), 32'd0);
      step();
      chk("t1_hdr_valid", 32'(out_valid), 32'd1);
      chk("t1_hdr", out_data, 32'h5A00000A);
      chk("t1_hdr_last", 32'(out_last), 32'd0);
      step();
      chk("t1_val", out_data, 32'h00000064);
      chk("t1_val_last", 32'(out_last), 32'(WPR == 2));
`ifdef STRUCT_SER_CHECKSUM_EN
      step();
      chk("t6_csum", out_data, 32'h5A00006E);
      chk("t6_csum_last", 32'(out_last), 32'd1);
`endif
      step();
      chk("t1_done_valid", 32'(out_valid), 32'd0);
      chk("t1_records_sent", 32'(records_sent), 32'd1);

      // Flagged record
      in_data  = {1'b1, 32'hDEADBEEF, 8'hFF};
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("t2_hdr", out_data, 32'h5A0100FF);
      step();
      chk("t2_val", out_data, 32'hDEADBEEF);
      drain();
      chk("t2_records_sent", 32'(records_sent), 32'd2);

      // Backpressure hold and FIFO full
      out_ready = 1'b0;
      in_data   = {1'b0, 32'd100, 8'd10};
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_valid", 32'(out_valid), 32'd1);
         chk("t3_hold_hdr", out_data, 32'h5A00000A);
         in_valid = 1'b1;
         in_data  = {1'b0, 32'(32'h200 + (i < 3 ? i : 2)), 8'(8'h20 + (i < 3 ? i : 2))};
         #1;
         chk("t3_in_ready", 32'(in_ready), 32'(i < 2));
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();
      chk("t3_records_sent", 32'(records_sent), 32'd5);

      // Back-to-back records: continuous word stream
      rs0 = records_sent;
      fork
         begin
            for (int k = 0; k < 4; k++) begin
               int n = 0;
               in_data  = {k[0], 32'(32'h1000 + k), 8'(k)};
               in_valid = 1'b1;
               while (!in_ready && n < 50) begin
                  step();
                  n++;
               end
               step();
            end
            in_valid = 1'b0;
         end
         begin
            wait_valid();
            for (int j = 0; j < 4 * WPR; j++) begin
               chk("t4_valid", 32'(out_valid), 32'd1);
               chk("t4_last", 32'(out_last), 32'((j % WPR) == WPR - 1));
               step();
            end
         end
      join
      drain();
      chk("t4_records_sent", 32'(records_sent), 32'(rs0 + 16'd4));

      // Reset mid-record with one record queued
      out_ready = 1'b0;
      in_data   = {1'b0, 32'h0000ABCD, 8'h33};
      in_valid  = 1'b1;
      step();
      in_data = {1'b1, 32'h00001234, 8'h44};
      step();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t5_in_val", out_data, 32'h0000ABCD);
      chk("t5_busy_before", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(out_valid), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_records_sent", 32'(records_sent), 32'd0);
      chk("t5_rst_out_data", out_data, 32'd0);
      chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
      step();
      step();
      reset     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("t5_no_stale_valid", 32'(out_valid), 32'd0);
         chk("t5_no_stale_busy", 32'(busy), 32'd0);
         step();
      end

      // Recovery after reset
      in_data  = {1'b0, 32'd7, 8'd1};
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("t5_recover_hdr", out_data, 32'h5A000001);
      drain();
      chk("t5_recover_records_sent", 32'(records_sent), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
